jump_interrupt_controller: RTL
==============================

JUMP_INTERRUPT_CONTROLLER -- requirements
Module: jump_interrupt_controller

Interface
REQ-001 Parameter ADDR_W, default 8, program address width.
REQ-002 Parameter FLAG_W, default 4, ALU flag width.
REQ-003 Parameter NUM_IRQ, default 4, interrupt channel count (1..8).
REQ-004 Parameter STACK_DEPTH, default 4, return-context stack entries (1..16).
REQ-005 Parameter VEC_BASE, default 8'hF0, address of channel-0 vector; VEC_STRIDE, default 2, vector spacing.
REQ-006 Port clk  input  1  single clock; all state on rising edge.
REQ-007 Port reset  input  1  asynchronous, active-low reset.
REQ-008 Port irq  input  NUM_IRQ  level interrupt lines, bit 0 highest priority.
REQ-009 Port cur_addr  input  ADDR_W  address of instruction currently in decode.
REQ-010 Port flags  input  FLAG_W  current execute-stage flags.
REQ-011 Port jmp_req / jmp_target  input  1 / ADDR_W  taken-jump request and destination from decode.
REQ-012 Port ret_req  input  1  return-from-interrupt decoded.
REQ-013 Port stall  input  1  pipeline stall; blocks interrupt entry only.
REQ-014 Port pc_mux_sel / jmp_loc  output  1 / ADDR_W  PC redirect strobe and target.
REQ-015 Port irq_ack  output  NUM_IRQ  one-hot one-cycle acknowledge.
REQ-016 Port flags_restore / flags_restore_vld  output  FLAG_W / 1  popped flags and one-cycle strobe.
REQ-017 Port nest_level  output  clog2(STACK_DEPTH+1)  current stack occupancy.
REQ-018 Port stack_full / err_underflow  output  1 / 1  full indication; sticky underflow error.

Function
REQ-019 All outputs SHALL be registered; redirect appears the cycle after the causing input.
REQ-020 Pending bit i SHALL set on a 0->1 edge of irq[i] and clear only on acknowledge or reset.
REQ-021 Eligible channel SHALL be the lowest-index pending channel with priority strictly higher than the in-service level (idle level = NUM_IRQ).
REQ-022 Entry SHALL occur when an eligible channel exists, stall=0, jmp_req=0, ret_req=0, stack_full=0.
REQ-023 On entry: push {cur_addr, flags, previous level}; pc_mux_sel=1; jmp_loc=VEC_BASE+idx*VEC_STRIDE (mod 2^ADDR_W); irq_ack[idx]=1; pending[idx] cleared; level=idx.
REQ-024 On ret_req with stack non-empty: pop; pc_mux_sel=1; jmp_loc=saved address; flags_restore_vld=1; level=saved level.
REQ-025 On ret_req with stack empty: no redirect, err_underflow set until reset.
REQ-026 On jmp_req (no ret_req): pc_mux_sel=1, jmp_loc=jmp_target.
REQ-027 Priority for the same cycle: ret_req > jmp_req > interrupt entry; a deferred interrupt stays pending.
REQ-028 stack_full SHALL equal (nest_level==STACK_DEPTH); an eligible interrupt stays pending while full.
REQ-029 pc_mux_sel, irq_ack and flags_restore_vld SHALL be single-cycle pulses; otherwise 0.

Reset
REQ-030 reset low SHALL immediately clear pending, stack pointer, level (=NUM_IRQ), err_underflow and every output to 0.
REQ-031 Interrupt edges during reset SHALL be ignored; edge detector samples irq as 0 on release.

Configuration
REQ-032 Macro JIC_NEST_EN defined: preemption by higher-priority channels per REQ-021.
REQ-033 JIC_NEST_EN undefined: entry only when nest_level==0; stack depth still STACK_DEPTH for ret bookkeeping.

Structure
REQ-034 Package jic_pkg SHALL hold the stack-entry struct typedef and default parameter constants.
REQ-035 Sub-module jic_prio_enc SHALL implement the masked priority encoder (pending, level -> valid, idx).

Verification
REQ-036 Reset release, irq[2] rises, cur_addr=8'h10, flags=4'hA -> next cycle pc_mux_sel=1, jmp_loc=8'hF4, irq_ack=4'b0100, nest_level=1.
REQ-037 In service of ch2, irq[0] rises -> jmp_loc=8'hF0, nest_level=2 (JIC_NEST_EN); without the macro no entry until ret.
REQ-038 Two ret_req after REQ-037 -> jmp_loc returns to nested address then 8'h10, flags_restore=4'hA, nest_level=0.
REQ-039 irq[1] edge with jmp_req=1, jmp_target=8'h30 same cycle -> jmp_loc=8'h30 first, interrupt redirect the following cycle.
REQ-040 STACK_DEPTH=1, ch3 in service, irq[0] rises -> stack_full=1, no ack; ret_req -> ch0 entered the cycle after the return; ret_req with empty stack -> err_underflow=1, no redirect.

Source files
------------

// File: rtl/jic_pkg.sv
// jic_pkg: shared defaults and the saved return-context type
// for the jump/interrupt controller.
package jic_pkg;

  localparam int JIC_ADDR_W      = 8;
  localparam int JIC_FLAG_W      = 4;
  localparam int JIC_NUM_IRQ     = 4;
  localparam int JIC_STACK_DEPTH = 4;
  localparam int JIC_VEC_BASE    = 'hF0;
  localparam int JIC_VEC_STRIDE  = 2;

  // Context fields are sized for the largest legal configuration
  localparam int JIC_ADDR_MAX = 32;
  localparam int JIC_FLAG_MAX = 16;
  localparam int JIC_LVL_MAX  = 4;

  typedef struct packed {
    logic [JIC_ADDR_MAX-1:0] addr;
    logic [JIC_FLAG_MAX-1:0] flags;
    logic [JIC_LVL_MAX-1:0]  lvl;
  } jic_ctx_t;

endpackage

// File: rtl/jic_prio_enc.sv
// jic_prio_enc: lowest-index pending channel whose index
// is strictly below the in-service level.
module jic_prio_enc
  import jic_pkg::*;
#(
  parameter int N  = JIC_NUM_IRQ,
  parameter int LW = 3,
  parameter int IW = 2
)(
  input  logic [N-1:0]  i_pend,
  input  logic [LW-1:0] i_level,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_pend[i] && (i < int'(i_level))) begin
        o_valid = 1'b1;
        o_idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/jump_interrupt_controller.sv
// jump_interrupt_controller: PC redirect for jumps, IRQ entry, return.
// Define JIC_NEST_EN to allow preemption by higher-priority channels.
module jump_interrupt_controller
  import jic_pkg::*;
#(
  parameter int ADDR_W      = JIC_ADDR_W,
  parameter int FLAG_W      = JIC_FLAG_W,
  parameter int NUM_IRQ     = JIC_NUM_IRQ,
  parameter int STACK_DEPTH = JIC_STACK_DEPTH,
  parameter int VEC_BASE    = JIC_VEC_BASE,
  parameter int VEC_STRIDE  = JIC_VEC_STRIDE
)(
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_IRQ-1:0]               irq,
  input  logic [ADDR_W-1:0]                cur_addr,
  input  logic [FLAG_W-1:0]                flags,
  input  logic                             jmp_req,
  input  logic [ADDR_W-1:0]                jmp_target,
  input  logic                             ret_req,
  input  logic                             stall,
  output logic                             pc_mux_sel,
  output logic [ADDR_W-1:0]                jmp_loc,
  output logic [NUM_IRQ-1:0]               irq_ack,
  output logic [FLAG_W-1:0]                flags_restore,
  output logic                             flags_restore_vld,
  output logic [$clog2(STACK_DEPTH+1)-1:0] nest_level,
  output logic                             stack_full,
  output logic                             err_underflow
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int LW   = $clog2(NUM_IRQ + 1);
  localparam int IW   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic [NUM_IRQ-1:0] r_irq_q;
  logic [NUM_IRQ-1:0] r_pend;
  logic [LW-1:0]      r_level;
  logic [SP_W-1:0]    r_sp;
  jic_ctx_t           r_stk [STACK_DEPTH];

  logic [NUM_IRQ-1:0] w_pend;
  logic [NUM_IRQ-1:0] w_onehot;
  logic               w_valid;
  logic [IW-1:0]      w_idx;
  logic               w_empty;
  logic               w_gate;
  logic               w_jmp;
  logic               w_entry;
  logic [SP_W-1:0]    w_sp_inc;
  logic [ADDR_W-1:0]  w_vec;
  jic_ctx_t           w_top;
  jic_ctx_t           w_push;
  logic               w_unused;

  // A fresh edge is eligible in the same cycle it is seen
  assign w_pend   = r_pend | (irq & ~r_irq_q);
  assign w_empty  = (r_sp == '0);
  assign w_sp_inc = r_sp + SP_W'(1);
  assign w_onehot = NUM_IRQ'(1) << w_idx;
  assign w_vec    = ADDR_W'(VEC_BASE + int'(w_idx) * VEC_STRIDE);

`ifdef JIC_NEST_EN
  assign w_gate = 1'b1;
`else
  assign w_gate = w_empty;
`endif

  assign w_jmp   = jmp_req & ~ret_req;
  assign w_entry = w_valid & w_gate & ~stall & ~jmp_req
                 & ~ret_req & ~stack_full;

  assign w_push = '{
    addr:  JIC_ADDR_MAX'(cur_addr),
    flags: JIC_FLAG_MAX'(flags),
    lvl:   JIC_LVL_MAX'(r_level)
  };

  assign nest_level = r_sp;
  assign w_unused   = ^w_top;

  jic_prio_enc #(
    .N  (NUM_IRQ),
    .LW (LW),
    .IW (IW)
  ) u_prio (
    .i_pend  (w_pend),
    .i_level (r_level),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  always_comb begin
    w_top = r_stk[0];
    for (int i = 1; i < STACK_DEPTH; i++) begin
      if (int'(r_sp) == i + 1) w_top = r_stk[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) r_stk[i] <= '0;
    end else if (w_entry) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (int'(r_sp) == i) r_stk[i] <= w_push;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq_q           <= '0;
      r_pend            <= '0;
      r_level           <= LW'(NUM_IRQ);
      r_sp              <= '0;
      pc_mux_sel        <= 1'b0;
      jmp_loc           <= '0;
      irq_ack           <= '0;
      flags_restore     <= '0;
      flags_restore_vld <= 1'b0;
      stack_full        <= 1'b0;
      err_underflow     <= 1'b0;
    end else begin
      r_irq_q           <= irq;
      r_pend            <= w_pend;
      pc_mux_sel        <= 1'b0;
      irq_ack           <= '0;
      flags_restore_vld <= 1'b0;
      unique case (1'b1)
        ret_req: begin
          if (!w_empty) begin
            r_sp              <= r_sp - SP_W'(1);
            stack_full        <= 1'b0;
            pc_mux_sel        <= 1'b1;
            jmp_loc           <= w_top.addr[ADDR_W-1:0];
            flags_restore     <= w_top.flags[FLAG_W-1:0];
            flags_restore_vld <= 1'b1;
            r_level           <= w_top.lvl[LW-1:0];
          end else begin
            err_underflow <= 1'b1;
          end
        end
        w_jmp: begin
          pc_mux_sel <= 1'b1;
          jmp_loc    <= jmp_target;
        end
        w_entry: begin
          r_pend     <= w_pend & ~w_onehot;
          r_sp       <= w_sp_inc;
          stack_full <= (w_sp_inc == SP_W'(STACK_DEPTH));
          pc_mux_sel <= 1'b1;
          jmp_loc    <= w_vec;
          irq_ack    <= w_onehot;
          r_level    <= LW'(w_idx);
        end
        default: ;
      endcase
    end
  end

endmodule
